// File: rtl/receptor_quadro_medidas.sv
// Decodes 12-character distance frames ("ddd#" x 3) from a 7E1 receiver stream
// into three 12-bit measurements, with silence-based resynchronisation after errors.
module receptor_quadro_medidas #(
    parameter int TIMEOUT_CICLOS = 500_000,
    parameter int N_TIMEOUT      = 19
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  dado_ascii,
    input  logic        dado_pronto,
    output logic [11:0] medida1,
    output logic [11:0] medida2,
    output logic [11:0] medida3,
    output logic        medidas_validas,
    output logic        erro_quadro,
    output logic [7:0]  contagem_erros,
    output logic [3:0]  db_estado
);

    typedef enum logic [3:0] {
        SINCRONIZA = 4'd0,
        OCIOSO     = 4'd1,
        DIGITO     = 4'd2,
        SEPARADOR  = 4'd3,
        ATUALIZA   = 4'd4,
        ERRO       = 4'd5
    } estado_t;

    localparam logic [N_TIMEOUT-1:0] LIMITE = N_TIMEOUT'(TIMEOUT_CICLOS - 1);

    estado_t               estado, prox_estado;
    logic [N_TIMEOUT-1:0]  cont_ocioso;
    logic [2:0][11:0]      sombra;
    logic [1:0]            idx_digito;
    logic [1:0]            idx_sensor;
    logic                  e_digito;
    logic                  e_separador;
    logic                  estouro;

    assign e_digito    = (dado_ascii[6:4] == 3'b011);
    assign e_separador = (dado_ascii == 7'h23);
    assign estouro     = (cont_ocioso == LIMITE);

    always_ff @(posedge clock) begin
        if (reset) estado <= SINCRONIZA;
        else       estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            SINCRONIZA: begin
                if (!dado_pronto && estouro) prox_estado = OCIOSO;
            end
            OCIOSO: begin
                if (dado_pronto) prox_estado = e_digito ? DIGITO : ERRO;
            end
            DIGITO: begin
                if (dado_pronto) begin
                    if (!e_digito)              prox_estado = ERRO;
                    else if (idx_digito == 2'd2) prox_estado = SEPARADOR;
                end else if (estouro) begin
                    prox_estado = ERRO;
                end
            end
            SEPARADOR: begin
                if (dado_pronto) begin
                    if (!e_separador)            prox_estado = ERRO;
                    else if (idx_sensor == 2'd2) prox_estado = ATUALIZA;
                    else                         prox_estado = DIGITO;
                end else if (estouro) begin
                    prox_estado = ERRO;
                end
            end
            ATUALIZA: prox_estado = OCIOSO;
            ERRO:     prox_estado = SINCRONIZA;
            default:  prox_estado = SINCRONIZA;
        endcase
    end

    always_comb begin
        medidas_validas = (estado == ATUALIZA);
        erro_quadro     = (estado == ERRO);
        db_estado       = estado;
    end

    // Measurements load on the edge entering ATUALIZA so they are already
    // stable during the cycle medidas_validas is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            cont_ocioso    <= '0;
            sombra         <= '0;
            idx_digito     <= '0;
            idx_sensor     <= '0;
            medida1        <= '0;
            medida2        <= '0;
            medida3        <= '0;
            contagem_erros <= '0;
        end else begin
            case (estado)
                SINCRONIZA, DIGITO, SEPARADOR: begin
                    if (dado_pronto)   cont_ocioso <= '0;
                    else if (!estouro) cont_ocioso <= cont_ocioso + 1'b1;
                end
                default: cont_ocioso <= '0;
            endcase

            if (dado_pronto && e_digito && estado == OCIOSO) begin
                sombra[0][11:8] <= dado_ascii[3:0];
                idx_digito      <= 2'd1;
                idx_sensor      <= 2'd0;
            end

            if (dado_pronto && e_digito && estado == DIGITO) begin
                case (idx_digito)
                    2'd0:    sombra[idx_sensor][11:8] <= dado_ascii[3:0];
                    2'd1:    sombra[idx_sensor][7:4]  <= dado_ascii[3:0];
                    default: sombra[idx_sensor][3:0]  <= dado_ascii[3:0];
                endcase
                idx_digito <= idx_digito + 2'd1;
            end

            if (dado_pronto && e_separador && estado == SEPARADOR && idx_sensor != 2'd2) begin
                idx_sensor <= idx_sensor + 2'd1;
                idx_digito <= 2'd0;
            end

            if (estado == SEPARADOR && prox_estado == ATUALIZA) begin
                medida1 <= sombra[0];
                medida2 <= sombra[1];
                medida3 <= sombra[2];
            end

            if (estado == ATUALIZA || estado == ERRO) begin
                idx_digito <= 2'd0;
                idx_sensor <= 2'd0;
            end

            if (prox_estado == ERRO && estado != ERRO && contagem_erros != 8'hFF)
                contagem_erros <= contagem_erros + 8'd1;
        end
    end

endmodule

// File: tb/tb_receptor_quadro_medidas.sv
// Scoreboard bench: an event-level frame model predicts update/error pulses and
// their exact cycles; a negedge monitor pops and compares them.
module tb_receptor_quadro_medidas;

    localparam int TO = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  dado_ascii = '0;
    logic        dado_pronto = 1'b0;
    logic [11:0] medida1, medida2, medida3;
    logic        medidas_validas, erro_quadro;
    logic [7:0]  contagem_erros;
    logic [3:0]  db_estado;

    receptor_quadro_medidas #(.TIMEOUT_CICLOS(TO), .N_TIMEOUT(7)) dut (
        .clock(clock), .reset(reset), .dado_ascii(dado_ascii), .dado_pronto(dado_pronto),
        .medida1(medida1), .medida2(medida2), .medida3(medida3),
        .medidas_validas(medidas_validas), .erro_quadro(erro_quadro),
        .contagem_erros(contagem_erros), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          upd;
        int          at;
        logic [11:0] m1, m2, m3;
        logic [7:0]  cnt;
    } ev_t;
    ev_t fila[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: mode 0 = waiting for silence, 1 = between frames, 2 = inside frame
    int          m_mode = 0;
    int          m_s = 0;
    int          m_l = 0;
    int          m_pos = 0;
    logic [11:0] m_buf[3];
    logic [11:0] m_pub[3] = '{12'h0, 12'h0, 12'h0};
    int          m_cnt = 0;

    function automatic void push_ev(input bit upd, input int at);
        ev_t e;
        e.upd = upd; e.at = at;
        e.m1 = m_pub[0]; e.m2 = m_pub[1]; e.m3 = m_pub[2];
        e.cnt = 8'(m_cnt);
        fila.push_back(e);
    endfunction

    function automatic void err_at(input int at);
        if (m_cnt < 255) m_cnt++;
        push_ev(1'b0, at);
        m_mode = 0;
        m_s = at + 1;
    endfunction

    function automatic void mdl_advance(input int e);
        if (m_mode == 2 && e > m_l + TO) err_at(m_l + TO);
    endfunction

    function automatic void mdl_char(input int e, input logic [6:0] c);
        bit is_dig, want_sep;
        mdl_advance(e);
        is_dig = (c >= 7'h30 && c <= 7'h3F);
        if (m_mode == 0) begin
            if (e > m_s + TO) m_mode = 1;
            else begin m_s = e; return; end
        end
        if (m_mode == 1) begin
            if (is_dig) begin
                m_buf[0] = {c[3:0], 8'h00};
                m_pos = 1; m_mode = 2; m_l = e;
            end else err_at(e);
            return;
        end
        want_sep = (m_pos % 4 == 3);
        if (want_sep ? (c == 7'h23) : is_dig) begin
            if (!want_sep) m_buf[m_pos / 4] = m_buf[m_pos / 4] | (12'(c[3:0]) << (8 - 4 * (m_pos % 4)));
            else if (m_pos < 11) m_buf[m_pos / 4 + 1] = 12'h000;
            m_l = e;
            m_pos++;
            if (m_pos == 12) begin
                m_pub = m_buf;
                push_ev(1'b1, e);
                m_mode = 1;
            end
        end else err_at(e);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        mdl_advance(cyc + n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [6:0] c, input int gap);
        mdl_char(cyc + gap, c);
        repeat (gap - 1) tick();
        dado_ascii = c;
        dado_pronto = 1'b1;
        tick();
        dado_pronto = 1'b0;
    endtask

    task automatic send_str(input string s, input int first_gap, input int gap);
        for (int i = 0; i < s.len(); i++) send(7'(s[i]), (i == 0) ? first_gap : gap);
    endtask

    task automatic do_reset();
        int n;
        idle(2);
        n = cyc;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_mode = 0; m_s = n + 2; m_cnt = 0;
        m_pub = '{12'h0, 12'h0, 12'h0};
    endtask

    always @(negedge clock) begin
        if (!reset && (medidas_validas || erro_quadro)) begin
            if (fila.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: got valid=%0b err=%0b expected none (cycle %0d)",
                         medidas_validas, erro_quadro, cyc);
            end else begin
                ev_t e;
                e = fila.pop_front();
                chk("event_kind", {30'd0, medidas_validas, erro_quadro}, e.upd ? 32'd2 : 32'd1);
                chk("event_cycle", cyc, e.at);
                chk("medida1", medida1, e.m1);
                chk("medida2", medida2, e.m2);
                chk("medida3", medida3, e.m3);
                chk("contagem_erros", contagem_erros, e.cnt);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [6:0] fr[12];
        int long_at, g0, gap;

        do_reset();
        chk("reset_medida1", medida1, 12'h000);
        chk("reset_medida2", medida2, 12'h000);
        chk("reset_medida3", medida3, 12'h000);
        chk("reset_flags", {medidas_validas, erro_quadro}, 2'b00);
        chk("reset_contagem", contagem_erros, 8'd0);
        chk("reset_estado", db_estado, 4'd0);

        send_str("123#456#:;<#", TO + 5, 3);
        idle(3);
        chk("t1_medida1", medida1, 12'h123);
        chk("t1_medida2", medida2, 12'h456);
        chk("t1_medida3", medida3, 12'hABC);

        send_str("12X", 5, 3);
        idle(3);
        chk("t2_contagem", contagem_erros, 8'd1);
        chk("t2_medida1_kept", medida1, 12'h123);
        send_str("000#111#222#", TO + 5, 3);
        idle(3);
        chk("t2_medida3", medida3, 12'h222);

        send_str("12", 5, 3);
        idle(150);
        chk("t3_estado", db_estado, 4'd0);
        chk("t3_medida2_kept", medida2, 12'h111);

        send_str("1234", 60, 3);
        send_str("987#654#321#", 3, 3);
        idle(3);
        chk("t4_resync_ignored", medida1, 12'h000);
        send_str("987#654#321#", TO + 5, 3);
        idle(3);
        chk("t4_medida1", medida1, 12'h987);

        send_str("123#45", TO + 5, 3);
        do_reset();
        chk("t5_medida1", medida1, 12'h000);
        chk("t5_contagem", contagem_erros, 8'd0);
        chk("t5_estado", db_estado, 4'd0);
        send_str("111#222#333#", 3, 3);
        idle(3);
        chk("t5_ignored", medida2, 12'h000);
        send_str("456#789#012#", TO + 5, 3);
        idle(3);
        chk("t5_medida3", medida3, 12'h012);

        for (int i = 0; i < 300; i++) send(7'h58, TO + 2);
        idle(3);
        chk("t6_saturated", contagem_erros, 8'd255);

        do_reset();
        for (int f = 0; f < 40; f++) begin
            for (int p = 0; p < 12; p++)
                fr[p] = (p % 4 == 3) ? 7'h23 : 7'h30 + 7'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) fr[$urandom_range(0, 11)] = 7'($urandom_range(0, 127));
            long_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 11)) : -1;
            g0 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 20)) : int'($urandom_range(TO + 1, TO + 30));
            for (int p = 0; p < 12; p++) begin
                if (p == 0)            gap = g0;
                else if (p == long_at) gap = int'($urandom_range(TO - 1, TO + 2));
                else                   gap = int'($urandom_range(2, 12));
                send(fr[p], gap);
            end
        end

        idle(TO + 50);
        chk("queue_drained", fila.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
